fdiv_seq: RTL
=============

Name: fdiv_seq

Overview:
- Iterative IEEE-754 binary32 divider, computing rslt = x / y. It is the inverse-operation companion to the combinational fmul in the FPU datapath.
- Radix-2 restoring division, one quotient bit per clock.
- Fixed latency, with a req/busy/done handshake.
- Rounding is round-to-nearest-even only. The flag encoding matches fmul.

Parameters:
None (fixed binary32 function; latency is a design constant, L = 29).

Ports:
clk    in   1   clock; all state updates on rising edge
reset  in   1   synchronous reset, active-low (0 = reset)
req    in   1   start; sampled only while busy=0
x      in   32  dividend, binary32; captured when req accepted
y      in   32  divisor, binary32; captured when req accepted
busy   out  1   high from the cycle after acceptance until done
done   out  1   one-cycle pulse; rslt/flag valid from this cycle
rslt   out  32  quotient; held until next done
flag   out  5   [4] NV invalid, [3] DZ divide-by-zero, [2] OF overflow, [1] UF underflow, [0] NX inexact

Behaviour:
- Reset (reset=0 at an edge): state IDLE; busy=0, done=0, rslt=0, flag=0.
  - Reset mid-operation aborts the operation: no done pulse, and rslt/flag are cleared.
- States: IDLE -> PRE -> DIV (26 cycles, counter 25..0) -> RND -> IDLE.
- Acceptance:
  - IDLE with req=1: capture x and y, go to PRE, busy=1.
  - req while busy: ignored, with no queueing.
  - req in the same cycle as done: accepted, so back-to-back operations are allowed.
- PRE:
  - Decode classes: zero, subnormal, normal, inf, qNaN, sNaN.
  - Normalize subnormal significands with a leading-zero count, adjusting the exponent (10-bit signed).
  - Biased exponent e = ex - ey + 127.
  - If mx < my: mx <<= 1 and e -= 1, so the significand ratio is in [1,2).
- DIV:
  - Restoring step: rem = rem - my if non-negative, else restore; shift left.
  - 26 quotient bits: 1 integer bit, 23 fraction bits, guard bit, round bit.
  - sticky = (final rem != 0).
- RND:
  - If e <= 0: right-shift the quotient by 1-e, ORing the shifted-out bits into sticky. A shift > 26 yields 0 with sticky = any nonzero.
  - Round to nearest even.
  - A mantissa carry-out increments the exponent; a subnormal that rounds up to 2^-126 becomes a normal result.
  - done=1 in the cycle after RND. busy drops in that same cycle.
  - Latency: done is high in cycle N+29, where req was accepted at edge N.
- Special cases: they take the same fixed latency, with the result resolved in PRE. Priority order:
  1. x NaN: rslt = x | 0x00400000.
  2. Else y NaN: rslt = y | 0x00400000.
     - For 1 and 2: NV = either operand is an sNaN.
  3. inf/inf or 0/0: rslt = 0xFFC00000, NV.
  4. finite nonzero / 0: signed inf, DZ.
  5. inf / finite: signed inf, no flags.
  6. 0 / nonzero, or finite / inf: signed zero, no flags.
- Sign is x[31]^y[31] for all non-NaN results.
- Flags:
  - NX = guard|round|sticky is nonzero after alignment.
  - OF: the rounded exponent is >= 255. Then rslt = signed inf, flags OF|NX.
  - UF = tiny & NX, with tininess detected after rounding (unbounded-exponent result < 2^-126).
  - A result that rounds to zero gives signed zero, flags UF|NX.
- Widths: the exponent path is 10-bit two's complement. The remainder is 26 bits, so no overflow is possible.

Test Plan:
- 0x40400000 / 0x40000000 (3/2) -> rslt 0x3FC00000, flag 0x00; done exactly at cycle N+29, busy high for cycles N+1..N+28.
- 0x3F800000 / 0x40400000 (1/3) -> 0x3EAAAAAB, flag 0x01.
- Specials:
  - 0x3F800000 / 0x00000000 -> 0x7F800000, flag 0x08.
  - 0x00000000 / 0x00000000 -> 0xFFC00000, flag 0x10.
  - 0x7F800001 / 0x3F800000 -> 0x7FC00001, flag 0x10.
  - 0xFF800000 / 0x40000000 -> 0xFF800000, flag 0x00.
- Subnormal:
  - 0x00800000 / 0x40000000 -> 0x00400000, flag 0x00.
  - 0x00000001 / 0x40000000 -> 0x00000000, flag 0x03 (tie to even).
  - 0x00000003 / 0x40000000 -> 0x00000002, flag 0x03.
- Overflow: 0x7F7FFFFF / 0x3F000000 -> 0x7F800000, flag 0x05.
- Handshake/reset:
  - req re-pulsed at N+5 -> ignored; a single done at N+29.
  - req held high through done -> a second operation starts with its done at N+58.
  - reset=0 at N+10 -> busy=0 next cycle, no done, rslt=0, flag=0.

Source files
------------

// File: rtl/fdiv_seq.sv
// rtl/fdiv_seq.sv - iterative binary32 divider, radix-2 restoring, fixed 29-cycle latency
// Round-to-nearest-even only; specials are resolved in PRE and carried to RND.
module fdiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic [31:0] x,
   input  logic [31:0] y,
   output logic        busy,
   output logic        done,
   output logic [31:0] rslt,
   output logic [4:0]  flag
);

   typedef enum logic [1:0] {S_IDLE, S_PRE, S_DIV, S_RND} state_t;

   state_t      r_state, w_next;
   logic        w_accept;
   logic [31:0] r_x, r_y;
   logic [25:0] r_rem, r_q;
   logic [23:0] r_my;
   logic [9:0]  r_e;
   logic [4:0]  r_cnt;
   logic        r_sign, r_spec;
   logic [31:0] r_sres;
   logic [4:0]  r_sflag;
   logic        r_done;
   logic [31:0] r_rslt;
   logic [4:0]  r_flag;

   function automatic logic [4:0] lzc24(input logic [23:0] v);
      logic [4:0] n;
      logic       found;
      n = 5'd0;
      found = 1'b0;
      for (int i = 23; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + 5'd1;
         end
      end
      return n;
   endfunction

   // operand decode and normalisation
   logic [7:0]  w_xe, w_ye;
   logic [22:0] w_xf, w_yf;
   logic        w_xzero, w_yzero, w_xsub, w_ysub, w_xinf, w_yinf;
   logic        w_xnan, w_ynan, w_xsnan, w_ysnan;
   logic [4:0]  w_xlz, w_ylz;
   logic [23:0] w_xm, w_ym;
   logic [9:0]  w_xexp, w_yexp, w_e0, w_e1;
   logic        w_xlt;
   logic [25:0] w_rem0;

   assign w_xe    = r_x[30:23];
   assign w_xf    = r_x[22:0];
   assign w_ye    = r_y[30:23];
   assign w_yf    = r_y[22:0];
   assign w_xzero = (w_xe == 8'd0) && (w_xf == 23'd0);
   assign w_yzero = (w_ye == 8'd0) && (w_yf == 23'd0);
   assign w_xsub  = (w_xe == 8'd0) && (w_xf != 23'd0);
   assign w_ysub  = (w_ye == 8'd0) && (w_yf != 23'd0);
   assign w_xinf  = (w_xe == 8'hFF) && (w_xf == 23'd0);
   assign w_yinf  = (w_ye == 8'hFF) && (w_yf == 23'd0);
   assign w_xnan  = (w_xe == 8'hFF) && (w_xf != 23'd0);
   assign w_ynan  = (w_ye == 8'hFF) && (w_yf != 23'd0);
   assign w_xsnan = w_xnan && !w_xf[22];
   assign w_ysnan = w_ynan && !w_yf[22];
   assign w_xlz   = lzc24({1'b0, w_xf});
   assign w_ylz   = lzc24({1'b0, w_yf});
   assign w_xm    = w_xsub ? ({1'b0, w_xf} << w_xlz) : {1'b1, w_xf};
   assign w_ym    = w_ysub ? ({1'b0, w_yf} << w_ylz) : {1'b1, w_yf};
   assign w_xexp  = w_xsub ? (10'd1 - {5'd0, w_xlz}) : {2'd0, w_xe};
   assign w_yexp  = w_ysub ? (10'd1 - {5'd0, w_ylz}) : {2'd0, w_ye};
   assign w_e0    = w_xexp - w_yexp + 10'd127;
   assign w_xlt   = w_xm < w_ym;
   assign w_e1    = w_xlt ? (w_e0 - 10'd1) : w_e0;
   assign w_rem0  = w_xlt ? {1'b0, w_xm, 1'b0} : {2'b0, w_xm};

   logic        w_spec;
   logic [31:0] w_sres;
   logic [4:0]  w_sflag;
   logic        w_sign;
   assign w_sign = r_x[31] ^ r_y[31];

   always_comb begin
      w_spec  = 1'b1;
      w_sres  = 32'd0;
      w_sflag = 5'd0;
      if (w_xnan) begin
         w_sres  = r_x | 32'h0040_0000;
         w_sflag = {w_xsnan | w_ysnan, 4'd0};
      end else if (w_ynan) begin
         w_sres  = r_y | 32'h0040_0000;
         w_sflag = {w_xsnan | w_ysnan, 4'd0};
      end else if ((w_xinf && w_yinf) || (w_xzero && w_yzero)) begin
         w_sres  = 32'hFFC0_0000;
         w_sflag = 5'b10000;
      end else if (w_yzero && !w_xinf) begin
         w_sres  = {w_sign, 8'hFF, 23'd0};
         w_sflag = 5'b01000;
      end else if (w_xinf) begin
         w_sres  = {w_sign, 8'hFF, 23'd0};
      end else if (w_xzero || w_yinf) begin
         w_sres  = {w_sign, 31'd0};
      end else begin
         w_spec  = 1'b0;
      end
   end

   // one restoring step per DIV cycle
   logic [25:0] w_diff;
   logic        w_neg;
   assign w_diff = r_rem - {2'b0, r_my};
   assign w_neg  = w_diff[25];

   // denormalising shift, rounding and flag generation
   logic        w_sub, w_sticky0;
   logic [9:0]  w_sh, w_ee, w_ee2;
   logic [51:0] w_wide;
   logic [25:0] w_qs;
   logic        w_st, w_g, w_rr, w_up, w_nx, w_of, w_tiny, w_uf;
   logic [24:0] w_mr;
   logic [23:0] w_man;
   logic [31:0] w_res;
   logic [4:0]  w_rflag;

   assign w_sticky0 = |r_rem;
   assign w_sub     = r_e[9] || (r_e == 10'd0);
   assign w_sh      = 10'd1 - r_e;
   assign w_wide    = {r_q, 26'd0} >> w_sh;

   always_comb begin
      w_qs = r_q;
      w_st = w_sticky0;
      if (w_sub) begin
         if (w_sh > 10'd26) begin
            w_qs = 26'd0;
            w_st = w_sticky0 | (|r_q);
         end else begin
            w_qs = w_wide[51:26];
            w_st = w_sticky0 | (|w_wide[25:0]);
         end
      end
   end

   assign w_g    = w_qs[1];
   assign w_rr   = w_qs[0] | w_st;
   assign w_up   = w_g & (w_rr | w_qs[2]);
   assign w_nx   = w_g | w_rr;
   assign w_mr   = {1'b0, w_qs[25:2]} + {24'd0, w_up};
   assign w_ee   = w_sub ? 10'd1 : r_e;
   assign w_ee2  = w_mr[24] ? (w_ee + 10'd1) : w_ee;
   assign w_man  = w_mr[24] ? w_mr[24:1] : w_mr[23:0];
   assign w_of   = !w_sub && (w_ee2 >= 10'd255);
   // tiny unless an e=0 quotient of all ones would round up into 2^-126
   assign w_tiny = r_e[9] || ((r_e == 10'd0) && !(&r_q[25:1]));
   assign w_uf   = w_tiny & w_nx;

   always_comb begin
      w_res   = {r_sign, (w_man[23] ? w_ee2[7:0] : 8'd0), w_man[22:0]};
      w_rflag = {3'b000, w_uf, w_nx};
      if (r_spec) begin
         w_res   = r_sres;
         w_rflag = r_sflag;
      end else if (w_of) begin
         w_res   = {r_sign, 8'hFF, 23'd0};
         w_rflag = 5'b00101;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (req) w_next = S_PRE;
         S_PRE:   w_next = S_DIV;
         S_DIV:   if (r_cnt == 5'd0) w_next = S_RND;
         S_RND:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_accept = (r_state == S_IDLE) && req;
      busy     = (r_state != S_IDLE);
      done     = r_done;
      rslt     = r_rslt;
      flag     = r_flag;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_x <= x;
         r_y <= y;
      end
      if (r_state == S_PRE) begin
         r_rem   <= w_rem0;
         r_my    <= w_ym;
         r_e     <= w_e1;
         r_q     <= 26'd0;
         r_cnt   <= 5'd25;
         r_sign  <= w_sign;
         r_spec  <= w_spec;
         r_sres  <= w_sres;
         r_sflag <= w_sflag;
      end else if (r_state == S_DIV) begin
         r_rem <= {(w_neg ? r_rem[24:0] : w_diff[24:0]), 1'b0};
         r_q   <= {r_q[24:0], ~w_neg};
         r_cnt <= r_cnt - 5'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_done <= 1'b0;
         r_rslt <= 32'd0;
         r_flag <= 5'd0;
      end else begin
         r_done <= (r_state == S_RND);
         if (r_state == S_RND) begin
            r_rslt <= w_res;
            r_flag <= w_rflag;
         end
      end
   end

endmodule
